// File: rtl/sens_par12_rx.sv
// Parallel 12-bit sensor receiver: registers the raw sensor bus once, then
// frames pixels by HACT/VACT and tracks line width, line count and sync errors.
module sens_par12_rx #(
    parameter int EXP_COLS = 66,
    parameter int EXP_ROWS = 18
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        en,
    input  logic [11:0] D,
    input  logic        BPF,
    input  logic        HACT,
    input  logic        VACT,
    input  logic        err_clr,
    output logic [11:0] pxd,
    output logic        pxd_valid,
    output logic        sol,
    output logic        sof,
    output logic        eof,
    output logic [15:0] frame_num,
    output logic [11:0] line_cnt,
    output logic [11:0] last_width,
    output logic        err_width,
    output logic        err_rows,
    output logic        err_sync
);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_SOF, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [11:0] d_s1;
    logic        bpf_s1, hact_s1, vact_s1;
    logic        hact_p, vact_p;
    logic [11:0] col_cnt;
    logic [15:0] frame_cnt;
    logic        sol_pend, sof_pend;

    logic        hact_rise, hact_fall, vact_rise, vact_fall;
    logic        pix_take, line_end, frame_end, enter_active, sync_err;
    logic [11:0] lines_inc, lines_final;

    assign frame_num = frame_cnt;

    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            d_s1    <= '0;
            bpf_s1  <= 1'b0;
            hact_s1 <= 1'b0;
            vact_s1 <= 1'b0;
            hact_p  <= 1'b0;
            vact_p  <= 1'b0;
        end else begin
            d_s1    <= D;
            bpf_s1  <= BPF;
            hact_s1 <= HACT;
            vact_s1 <= VACT;
            hact_p  <= hact_s1;
            vact_p  <= vact_s1;
        end
    end

    assign hact_rise    = hact_s1 & ~hact_p;
    assign hact_fall    = ~hact_s1 & hact_p;
    assign vact_rise    = vact_s1 & ~vact_p;
    assign vact_fall    = ~vact_s1 & vact_p;
    assign pix_take     = (state == ACTIVE) & hact_s1 & vact_s1 & ~bpf_s1;
    assign line_end     = (state == ACTIVE) & hact_fall;
    assign frame_end    = (state == ACTIVE) & vact_fall;
    assign enter_active = (state == WAIT_SOF) & en & vact_rise;
    assign sync_err     = hact_s1 & (~vact_s1 | bpf_s1);
    assign lines_inc    = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
    // A line closing in the same cycle as the frame still counts toward the row check
    assign lines_final  = line_end ? lines_inc : line_cnt;

    always_ff @(posedge MCLK) begin
        if (!MRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = ARM;
            ARM:      if (!en) state_nxt = IDLE;
                      else if (!vact_s1) state_nxt = WAIT_SOF;
            WAIT_SOF: if (!en) state_nxt = IDLE;
                      else if (vact_rise) state_nxt = ACTIVE;
            ACTIVE:   if (vact_fall) state_nxt = en ? WAIT_SOF : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            pxd        <= '0;
            pxd_valid  <= 1'b0;
            sol        <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_cnt  <= '0;
            line_cnt   <= '0;
            last_width <= '0;
            col_cnt    <= '0;
            sol_pend   <= 1'b0;
            sof_pend   <= 1'b0;
            err_width  <= 1'b0;
            err_rows   <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            pxd_valid <= pix_take;
            sol       <= pix_take & (hact_rise | sol_pend);
            sof       <= pix_take & sof_pend;
            eof       <= frame_end;
            if (pix_take) pxd <= d_s1;

            if (pix_take)       sol_pend <= 1'b0;
            else if (hact_rise) sol_pend <= 1'b1;

            if (enter_active)  sof_pend <= 1'b1;
            else if (pix_take) sof_pend <= 1'b0;

            if (hact_rise)
                col_cnt <= pix_take ? 12'd1 : 12'd0;
            else if (pix_take && col_cnt != 12'hFFF)
                col_cnt <= col_cnt + 12'd1;

            if (enter_active)  line_cnt <= '0;
            else if (line_end) line_cnt <= lines_inc;

            if (line_end)  last_width <= col_cnt;
            if (frame_end) frame_cnt  <= frame_cnt + 16'd1;

            // Newly detected errors win over a simultaneous clear
            err_width <= (line_end & (col_cnt != 12'(EXP_COLS))) | (err_width & ~err_clr);
            err_rows  <= (frame_end & (lines_final != 12'(EXP_ROWS))) | (err_rows & ~err_clr);
            err_sync  <= sync_err | (err_sync & ~err_clr);
        end
    end

endmodule

// File: tb/tb_sens_par12_rx.sv
// Directed bench for sens_par12_rx: a default-parameter instance and a second
// instance expecting 64 columns / 17 rows share the same sensor stimulus.
module tb_sens_par12_rx;

    logic        MCLK = 1'b0;
    logic        MRST, en, BPF, HACT, VACT, err_clr;
    logic [11:0] D;

    logic [11:0] pxd0, line_cnt0, last_width0;
    logic        pxd_valid0, sol0, sof0, eof0, err_width0, err_rows0, err_sync0;
    logic [15:0] frame_num0;
    logic [11:0] pxd1, line_cnt1, last_width1;
    logic        pxd_valid1, sol1, sof1, eof1, err_width1, err_rows1, err_sync1;
    logic [15:0] frame_num1;

    int checks = 0;
    int failures = 0;

    logic mon_clr = 1'b0;
    int valid_cnt, sol_cnt, sof_cnt, eof_cnt, pix_bad;
    int valid1_cnt, pix_bad1;
    logic [11:0] prev_pix, prev_pix1;

    sens_par12_rx dut0 (
        .MCLK(MCLK), .MRST(MRST), .en(en), .D(D), .BPF(BPF), .HACT(HACT), .VACT(VACT),
        .err_clr(err_clr), .pxd(pxd0), .pxd_valid(pxd_valid0), .sol(sol0), .sof(sof0),
        .eof(eof0), .frame_num(frame_num0), .line_cnt(line_cnt0), .last_width(last_width0),
        .err_width(err_width0), .err_rows(err_rows0), .err_sync(err_sync0)
    );

    sens_par12_rx #(.EXP_COLS(64), .EXP_ROWS(17)) dut1 (
        .MCLK(MCLK), .MRST(MRST), .en(en), .D(D), .BPF(BPF), .HACT(HACT), .VACT(VACT),
        .err_clr(err_clr), .pxd(pxd1), .pxd_valid(pxd_valid1), .sol(sol1), .sof(sof1),
        .eof(eof1), .frame_num(frame_num1), .line_cnt(line_cnt1), .last_width(last_width1),
        .err_width(err_width1), .err_rows(err_rows1), .err_sync(err_sync1)
    );

    always #5 MCLK = ~MCLK;

    // Output monitor: each line must be a ramp starting at 0 on the sol pixel
    always @(negedge MCLK) begin
        if (mon_clr) begin
            valid_cnt <= 0; sol_cnt <= 0; sof_cnt <= 0; eof_cnt <= 0; pix_bad <= 0;
            valid1_cnt <= 0; pix_bad1 <= 0; prev_pix <= '0; prev_pix1 <= '0;
        end else begin
            if (eof0) eof_cnt <= eof_cnt + 1;
            if (pxd_valid0) begin
                valid_cnt <= valid_cnt + 1;
                if (sol0) sol_cnt <= sol_cnt + 1;
                if (sof0) sof_cnt <= sof_cnt + 1;
                if (pxd0 !== (sol0 ? 12'h000 : prev_pix + 12'h001)) pix_bad <= pix_bad + 1;
                prev_pix <= pxd0;
            end else if (sol0 || sof0) pix_bad <= pix_bad + 1;
            if (pxd_valid1) begin
                valid1_cnt <= valid1_cnt + 1;
                if (pxd1 !== (sol1 ? 12'h000 : prev_pix1 + 12'h001)) pix_bad1 <= pix_bad1 + 1;
                prev_pix1 <= pxd1;
            end
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    // Ramp sensor model: cols pixels 0..cols-1 per line, rows lines per frame
    task automatic send_frame(input int cols, input int rows, input int stop_line,
                              input int en_line, input bit sim_fall);
        VACT = 1'b1; HACT = 1'b0; BPF = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < rows; r++) begin
            if (r == en_line) en = 1'b1;
            HACT = 1'b1;
            for (int c = 0; c < cols; c++) begin
                D = 12'(c);
                tick();
                if (r == stop_line && c == 9) return;
            end
            HACT = 1'b0; D = '0;
            if (sim_fall && r == rows - 1) begin
                VACT = 1'b0;
                repeat (4) tick();
                return;
            end
            repeat (3) tick();
        end
        VACT = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        MRST = 1'b0; en = 1'b0; D = 12'hFFF; BPF = 1'b0; HACT = 1'b0; VACT = 1'b0; err_clr = 1'b0;
        repeat (2) tick();
        checks++; if (pxd0 !== 12'h000) begin failures++; $display("[TB] FAIL reset_pxd got=%h exp=000", pxd0); end
        checks++; if (pxd_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_pxd_valid got=%b exp=0", pxd_valid0); end
        checks++; if ({sol0, sof0, eof0} !== 3'b000) begin failures++; $display("[TB] FAIL reset_sol_sof_eof got=%b exp=000", {sol0, sof0, eof0}); end
        checks++; if (frame_num0 !== 16'h0000) begin failures++; $display("[TB] FAIL reset_frame_num got=%h exp=0000", frame_num0); end
        checks++; if (line_cnt0 !== 12'h000) begin failures++; $display("[TB] FAIL reset_line_cnt got=%h exp=000", line_cnt0); end
        checks++; if (last_width0 !== 12'h000) begin failures++; $display("[TB] FAIL reset_last_width got=%h exp=000", last_width0); end
        checks++; if ({err_width0, err_rows0, err_sync0} !== 3'b000) begin failures++; $display("[TB] FAIL reset_errs got=%b exp=000", {err_width0, err_rows0, err_sync0}); end
        MRST = 1'b1; en = 1'b1; D = '0;
        repeat (5) tick();
        checks++; if (pxd0 !== 12'h000 || pxd_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=%h/%b exp=000/0", pxd0, pxd_valid0); end
    endtask

    task automatic test_frame();
        clear_monitor();
        send_frame(66, 18, -1, -1, 1'b0);
        checks++; if (valid_cnt !== 1188) begin failures++; $display("[TB] FAIL frame_valid_cnt got=%0d exp=1188", valid_cnt); end
        checks++; if (pix_bad !== 0) begin failures++; $display("[TB] FAIL frame_ramp_errors got=%0d exp=0", pix_bad); end
        checks++; if (sol_cnt !== 18) begin failures++; $display("[TB] FAIL frame_sol_cnt got=%0d exp=18", sol_cnt); end
        checks++; if (sof_cnt !== 1) begin failures++; $display("[TB] FAIL frame_sof_cnt got=%0d exp=1", sof_cnt); end
        checks++; if (eof_cnt !== 1) begin failures++; $display("[TB] FAIL frame_eof_cnt got=%0d exp=1", eof_cnt); end
        checks++; if (frame_num0 !== 16'd1) begin failures++; $display("[TB] FAIL frame_num got=%0d exp=1", frame_num0); end
        checks++; if (last_width0 !== 12'd66) begin failures++; $display("[TB] FAIL frame_last_width got=%0d exp=66", last_width0); end
        checks++; if (line_cnt0 !== 12'd18) begin failures++; $display("[TB] FAIL frame_line_cnt got=%0d exp=18", line_cnt0); end
        checks++; if ({err_width0, err_rows0, err_sync0} !== 3'b000) begin failures++; $display("[TB] FAIL frame_errs got=%b exp=000", {err_width0, err_rows0, err_sync0}); end
        checks++; if (err_width1 !== 1'b1) begin failures++; $display("[TB] FAIL cols64_err_width got=%b exp=1", err_width1); end
        checks++; if (err_rows1 !== 1'b1) begin failures++; $display("[TB] FAIL rows17_err_rows got=%b exp=1", err_rows1); end
        checks++; if (last_width1 !== 12'd66) begin failures++; $display("[TB] FAIL cols64_last_width got=%0d exp=66", last_width1); end
        checks++; if (valid1_cnt !== 1188 || pix_bad1 !== 0) begin failures++; $display("[TB] FAIL cols64_stream got=%0d/%0d exp=1188/0", valid1_cnt, pix_bad1); end
        checks++; if (err_sync1 !== 1'b0) begin failures++; $display("[TB] FAIL cols64_err_sync got=%b exp=0", err_sync1); end
    endtask

    task automatic test_latency();
        VACT = 1'b1;
        repeat (3) tick();
        HACT = 1'b1; D = 12'hABC;
        tick();
        checks++; if (pxd_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL lat_early_valid got=%b exp=0", pxd_valid0); end
        HACT = 1'b0; D = 12'h123;
        tick();
        checks++; if (pxd_valid0 !== 1'b1 || pxd0 !== 12'hABC) begin failures++; $display("[TB] FAIL lat_pixel got=%b/%h exp=1/abc", pxd_valid0, pxd0); end
        checks++; if ({sol0, sof0} !== 2'b11) begin failures++; $display("[TB] FAIL lat_sol_sof got=%b exp=11", {sol0, sof0}); end
        tick();
        checks++; if (pxd_valid0 !== 1'b0 || pxd0 !== 12'hABC) begin failures++; $display("[TB] FAIL lat_hold got=%b/%h exp=0/abc", pxd_valid0, pxd0); end
        checks++; if (last_width0 !== 12'd1 || line_cnt0 !== 12'd1) begin failures++; $display("[TB] FAIL lat_line_close got=%0d/%0d exp=1/1", last_width0, line_cnt0); end
        checks++; if (err_width0 !== 1'b1) begin failures++; $display("[TB] FAIL lat_err_width got=%b exp=1", err_width0); end
        clear_monitor();
        HACT = 1'b1; BPF = 1'b1; D = 12'h555;
        repeat (2) tick();
        HACT = 1'b0; BPF = 1'b0; D = '0;
        repeat (2) tick();
        checks++; if (valid_cnt !== 0 || pxd0 !== 12'hABC) begin failures++; $display("[TB] FAIL bpf_suppressed got=%0d/%h exp=0/abc", valid_cnt, pxd0); end
        checks++; if (err_sync0 !== 1'b1) begin failures++; $display("[TB] FAIL bpf_err_sync got=%b exp=1", err_sync0); end
        checks++; if (last_width0 !== 12'd0 || line_cnt0 !== 12'd2) begin failures++; $display("[TB] FAIL bpf_line_close got=%0d/%0d exp=0/2", last_width0, line_cnt0); end
        pulse_err_clr();
        checks++; if ({err_width0, err_rows0, err_sync0} !== 3'b000) begin failures++; $display("[TB] FAIL err_clr_all got=%b exp=000", {err_width0, err_rows0, err_sync0}); end
        VACT = 1'b0;
        repeat (4) tick();
        checks++; if (frame_num0 !== 16'd2 || err_rows0 !== 1'b1) begin failures++; $display("[TB] FAIL short_frame got=%0d/%b exp=2/1", frame_num0, err_rows0); end
        pulse_err_clr();
    endtask

    task automatic test_sync_err();
        clear_monitor();
        HACT = 1'b1;
        tick();
        HACT = 1'b0;
        repeat (2) tick();
        checks++; if (err_sync0 !== 1'b1) begin failures++; $display("[TB] FAIL sync_first got=%b exp=1", err_sync0); end
        HACT = 1'b1;
        tick();
        err_clr = 1'b1; HACT = 1'b0;
        tick();
        err_clr = 1'b0;
        tick();
        checks++; if (err_sync0 !== 1'b1) begin failures++; $display("[TB] FAIL sync_set_beats_clr got=%b exp=1", err_sync0); end
        pulse_err_clr();
        checks++; if (err_sync0 !== 1'b0) begin failures++; $display("[TB] FAIL sync_lone_clr got=%b exp=0", err_sync0); end
        checks++; if (valid_cnt !== 0) begin failures++; $display("[TB] FAIL sync_no_output got=%0d exp=0", valid_cnt); end
    endtask

    task automatic test_en_midframe();
        MRST = 1'b0; en = 1'b0;
        tick();
        MRST = 1'b1;
        repeat (3) tick();
        clear_monitor();
        send_frame(66, 18, -1, 5, 1'b0);
        checks++; if (valid_cnt !== 0 || eof_cnt !== 0) begin failures++; $display("[TB] FAIL en_mid_no_output got=%0d/%0d exp=0/0", valid_cnt, eof_cnt); end
        checks++; if (frame_num0 !== 16'd0) begin failures++; $display("[TB] FAIL en_mid_frame_num got=%0d exp=0", frame_num0); end
        clear_monitor();
        send_frame(66, 18, -1, -1, 1'b0);
        checks++; if (valid_cnt !== 1188 || pix_bad !== 0) begin failures++; $display("[TB] FAIL en_next_frame got=%0d/%0d exp=1188/0", valid_cnt, pix_bad); end
        checks++; if (frame_num0 !== 16'd1 || sof_cnt !== 1) begin failures++; $display("[TB] FAIL en_next_frame_num got=%0d/%0d exp=1/1", frame_num0, sof_cnt); end
        checks++; if ({err_width0, err_rows0, err_sync0} !== 3'b000) begin failures++; $display("[TB] FAIL en_next_errs got=%b exp=000", {err_width0, err_rows0, err_sync0}); end
    endtask

    task automatic test_reset_midframe();
        clear_monitor();
        send_frame(66, 18, 4, -1, 1'b0);
        MRST = 1'b0;
        tick();
        checks++; if (pxd0 !== 12'h000 || pxd_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pxd got=%h/%b exp=000/0", pxd0, pxd_valid0); end
        checks++; if ({sol0, sof0, eof0} !== 3'b000) begin failures++; $display("[TB] FAIL midrst_flags got=%b exp=000", {sol0, sof0, eof0}); end
        checks++; if (frame_num0 !== 16'd0 || line_cnt0 !== 12'd0 || last_width0 !== 12'd0) begin failures++; $display("[TB] FAIL midrst_counters got=%0d/%0d/%0d exp=0/0/0", frame_num0, line_cnt0, last_width0); end
        MRST = 1'b1; HACT = 1'b0; D = '0;
        clear_monitor();
        for (int r = 0; r < 2; r++) begin
            HACT = 1'b1;
            for (int c = 0; c < 10; c++) begin D = 12'(c); tick(); end
            HACT = 1'b0;
            repeat (3) tick();
        end
        VACT = 1'b0;
        repeat (4) tick();
        checks++; if (valid_cnt !== 0 || eof_cnt !== 0) begin failures++; $display("[TB] FAIL midrst_aborted got=%0d/%0d exp=0/0", valid_cnt, eof_cnt); end
        checks++; if (frame_num0 !== 16'd0 || err_sync0 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_abort_state got=%0d/%b exp=0/0", frame_num0, err_sync0); end
        clear_monitor();
        send_frame(66, 18, -1, -1, 1'b0);
        checks++; if (valid_cnt !== 1188 || pix_bad !== 0 || eof_cnt !== 1) begin failures++; $display("[TB] FAIL midrst_next_frame got=%0d/%0d/%0d exp=1188/0/1", valid_cnt, pix_bad, eof_cnt); end
        checks++; if (frame_num0 !== 16'd1) begin failures++; $display("[TB] FAIL midrst_frame_num got=%0d exp=1", frame_num0); end
    endtask

    task automatic test_simul_fall();
        pulse_err_clr();
        clear_monitor();
        send_frame(66, 18, -1, -1, 1'b1);
        checks++; if (line_cnt0 !== 12'd18 || last_width0 !== 12'd66) begin failures++; $display("[TB] FAIL simfall_line got=%0d/%0d exp=18/66", line_cnt0, last_width0); end
        checks++; if (err_rows0 !== 1'b0 || err_rows1 !== 1'b1) begin failures++; $display("[TB] FAIL simfall_err_rows got=%b/%b exp=0/1", err_rows0, err_rows1); end
        checks++; if (eof_cnt !== 1 || frame_num0 !== 16'd2) begin failures++; $display("[TB] FAIL simfall_eof got=%0d/%0d exp=1/2", eof_cnt, frame_num0); end
        checks++; if (err_sync0 !== 1'b0 || err_width0 !== 1'b0) begin failures++; $display("[TB] FAIL simfall_errs got=%b/%b exp=0/0", err_sync0, err_width0); end
    endtask

    task automatic test_many_frames();
        clear_monitor();
        repeat (18) send_frame(8, 2, -1, -1, 1'b0);
        checks++; if (frame_num0 !== 16'd20 || eof_cnt !== 18) begin failures++; $display("[TB] FAIL many_frames got=%0d/%0d exp=20/18", frame_num0, eof_cnt); end
        checks++; if (frame_num1 !== 16'd20) begin failures++; $display("[TB] FAIL many_frames_dut1 got=%0d exp=20", frame_num1); end
        force dut0.frame_cnt = 16'hFFFF;
        #1;
        release dut0.frame_cnt;
        tick();
        checks++; if (frame_num0 !== 16'hFFFF) begin failures++; $display("[TB] FAIL preload got=%h exp=ffff", frame_num0); end
        send_frame(8, 2, -1, -1, 1'b0);
        checks++; if (frame_num0 !== 16'h0000) begin failures++; $display("[TB] FAIL frame_wrap got=%h exp=0000", frame_num0); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_latency();
        test_sync_err();
        test_en_midframe();
        test_reset_midframe();
        test_simul_fall();
        test_many_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
